// File: rtl/systolic_tile.sv
// rtl/systolic_tile.sv - 8x8 output-stationary systolic int8 MAC tile
// Operands hop one PE per cycle (activations rightward, weights downward); each PE emits a 32-bit dot product.
module systolic_tile #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ROWS*DATA_W-1:0]       activate,
  input  logic [COLS*DATA_W-1:0]       weight,
  input  logic [CNT_W-1:0]             signCount,
  input  logic                         a_Valid_0,
  input  logic                         a_Valid_1,
  input  logic                         a_Valid_2,
  input  logic                         a_Valid_3,
  input  logic                         a_Valid_4,
  input  logic                         a_Valid_5,
  input  logic                         a_Valid_6,
  input  logic                         a_Valid_7,
  input  logic                         b_Valid_0,
  input  logic                         b_Valid_1,
  input  logic                         b_Valid_2,
  input  logic                         b_Valid_3,
  input  logic                         b_Valid_4,
  input  logic                         b_Valid_5,
  input  logic                         b_Valid_6,
  input  logic                         b_Valid_7,
  output logic [ROWS*COLS*ACC_W-1:0]   mData,
  output logic [ROWS*COLS-1:0]         mValid
);

  logic [7:0] a_lane_v;
  logic [7:0] b_lane_v;

  assign a_lane_v = {a_Valid_7, a_Valid_6, a_Valid_5, a_Valid_4,
                     a_Valid_3, a_Valid_2, a_Valid_1, a_Valid_0};
  assign b_lane_v = {b_Valid_7, b_Valid_6, b_Valid_5, b_Valid_4,
                     b_Valid_3, b_Valid_2, b_Valid_1, b_Valid_0};

  logic [DATA_W-1:0] a_in [ROWS][COLS];
  logic [DATA_W-1:0] b_in [ROWS][COLS];
  logic              av_in [ROWS][COLS];
  logic              bv_in [ROWS][COLS];

  logic [DATA_W-1:0] a_q  [ROWS][COLS];
  logic [DATA_W-1:0] b_q  [ROWS][COLS];
  logic              av_q [ROWS][COLS];
  logic              bv_q [ROWS][COLS];

  logic [ACC_W-1:0]  prod [ROWS][COLS];
  logic [ACC_W-1:0]  acc  [ROWS][COLS];
  logic [CNT_W-1:0]  cnt  [ROWS][COLS];
  logic              fire [ROWS][COLS];
  logic              last [ROWS][COLS];

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic signed [2*DATA_W-1:0] p_narrow;

      // Edge PEs take the port lanes; interior PEs take the neighbour's registered copy.
      if (gj == 0) begin : g_a_edge
        assign a_in[gi][gj]  = activate[gi*DATA_W +: DATA_W];
        assign av_in[gi][gj] = a_lane_v[gi];
      end else begin : g_a_hop
        assign a_in[gi][gj]  = a_q[gi][gj-1];
        assign av_in[gi][gj] = av_q[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in[gi][gj]  = weight[gj*DATA_W +: DATA_W];
        assign bv_in[gi][gj] = b_lane_v[gj];
      end else begin : g_b_hop
        assign b_in[gi][gj]  = b_q[gi-1][gj];
        assign bv_in[gi][gj] = bv_q[gi-1][gj];
      end

      assign p_narrow = $signed(a_in[gi][gj]) * $signed(b_in[gi][gj]);
      assign prod[gi][gj] = {{(ACC_W-2*DATA_W){p_narrow[2*DATA_W-1]}}, p_narrow};
      assign fire[gi][gj] = av_in[gi][gj] & bv_in[gi][gj];
      assign last[gi][gj] = (cnt[gi][gj] == signCount);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j]  <= '0;
          b_q[i][j]  <= '0;
          av_q[i][j] <= 1'b0;
          bv_q[i][j] <= 1'b0;
          acc[i][j]  <= '0;
          cnt[i][j]  <= '0;
        end
      end
      mData  <= '0;
      mValid <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j]  <= a_in[i][j];
          b_q[i][j]  <= b_in[i][j];
          av_q[i][j] <= av_in[i][j];
          bv_q[i][j] <= bv_in[i][j];
          mValid[i*COLS+j] <= fire[i][j] & last[i][j];
          // Completing fire publishes the sum and restarts the window in the same edge.
          if (fire[i][j]) begin
            if (last[i][j]) begin
              mData[(i*COLS+j)*ACC_W +: ACC_W] <= acc[i][j] + prod[i][j];
              acc[i][j] <= '0;
              cnt[i][j] <= '0;
            end else begin
              acc[i][j] <= acc[i][j] + prod[i][j];
              cnt[i][j] <= cnt[i][j] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_tile.sv
// tb/tb_systolic_tile.sv - directed and random checks of systolic_tile against a skewed dot-product model
module tb_systolic_tile;
  localparam int R    = 8;
  localparam int C    = 8;
  localparam int N    = R * C;
  localparam int HMAX = 2048;
  localparam int BMAX = 1000;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [63:0]    activate = '0;
  logic [63:0]    weight = '0;
  logic [15:0]    sc = '0;
  logic [7:0]     av_lanes = '0;
  logic [7:0]     bv_lanes = '0;
  logic [2047:0]  mdata;
  logic [63:0]    mvalid;

  int checks = 0;
  int errors = 0;

  systolic_tile dut (
    .clk(clk), .reset(reset), .activate(activate), .weight(weight), .signCount(sc),
    .a_Valid_0(av_lanes[0]), .a_Valid_1(av_lanes[1]), .a_Valid_2(av_lanes[2]), .a_Valid_3(av_lanes[3]),
    .a_Valid_4(av_lanes[4]), .a_Valid_5(av_lanes[5]), .a_Valid_6(av_lanes[6]), .a_Valid_7(av_lanes[7]),
    .b_Valid_0(bv_lanes[0]), .b_Valid_1(bv_lanes[1]), .b_Valid_2(bv_lanes[2]), .b_Valid_3(bv_lanes[3]),
    .b_Valid_4(bv_lanes[4]), .b_Valid_5(bv_lanes[5]), .b_Valid_6(bv_lanes[6]), .b_Valid_7(bv_lanes[7]),
    .mData(mdata), .mValid(mvalid)
  );

  always #5 clk = ~clk;

  logic signed [7:0] drv_a [R];
  logic signed [7:0] drv_b [C];
  logic              drv_av [R];
  logic              drv_bv [C];

  logic signed [7:0] ha  [HMAX][R];
  logic signed [7:0] hb  [HMAX][C];
  logic              hav [HMAX][R];
  logic              hbv [HMAX][C];
  int g = 0;

  logic signed [31:0] macc [N];
  int                 mcnt [N];
  logic [31:0]        exp_d [N];
  logic [63:0]        exp_v = '0;

  int          pcnt [N];
  int          pfirst_c [N];
  logic [31:0] pfirst_v [N];
  logic [31:0] plast_v [N];
  int          rel_c = 0;

  logic signed [7:0] ba  [R][BMAX];
  logic signed [7:0] bb  [C][BMAX];
  logic              bav [R][BMAX];
  logic              bbv [C][BMAX];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    check("mvalid", mvalid, exp_v);
    for (int p = 0; p < N; p++) begin
      if (exp_v[p])
        check($sformatf("mdata_pe%0d", p), {32'h0, mdata[p*32 +: 32]}, {32'h0, exp_d[p]});
      if (mvalid[p]) begin
        if (pcnt[p] == 0) begin
          pfirst_c[p] = rel_c;
          pfirst_v[p] = mdata[p*32 +: 32];
        end
        plast_v[p] = mdata[p*32 +: 32];
        pcnt[p]++;
      end
    end
  endtask

  // One cycle: check what the previous edge produced, then drive and model this cycle.
  task automatic step(input logic rst_v);
    int ka, kb, p;
    logic va, vb;
    logic signed [31:0] pv;
    @(negedge clk);
    compare_outputs();
    exp_v = '0;
    if (rst_v) begin
      reset = 1'b1;
      activate = '0; weight = '0; av_lanes = '0; bv_lanes = '0;
      for (int q = 0; q < N; q++) begin
        macc[q] = '0; mcnt[q] = 0; exp_d[q] = '0;
      end
      for (int k = 0; k <= 8; k++) begin
        if (g - k >= 0) begin
          for (int i = 0; i < R; i++) begin ha[g-k][i] = '0; hav[g-k][i] = 1'b0; end
          for (int j = 0; j < C; j++) begin hb[g-k][j] = '0; hbv[g-k][j] = 1'b0; end
        end
      end
    end else begin
      reset = 1'b0;
      for (int i = 0; i < R; i++) begin
        activate[i*8 +: 8] = drv_a[i];
        av_lanes[i] = drv_av[i];
        ha[g][i] = drv_a[i];
        hav[g][i] = drv_av[i];
      end
      for (int j = 0; j < C; j++) begin
        weight[j*8 +: 8] = drv_b[j];
        bv_lanes[j] = drv_bv[j];
        hb[g][j] = drv_b[j];
        hbv[g][j] = drv_bv[j];
      end
      for (int i = 0; i < R; i++) begin
        for (int j = 0; j < C; j++) begin
          ka = g - j; kb = g - i;
          va = 1'b0; vb = 1'b0;
          if (ka >= 0) va = hav[ka][i];
          if (kb >= 0) vb = hbv[kb][j];
          if (va && vb) begin
            p = i * C + j;
            pv = 32'(int'(ha[ka][i]) * int'(hb[kb][j]));
            if (mcnt[p] == int'(sc)) begin
              exp_d[p] = macc[p] + pv;
              exp_v[p] = 1'b1;
              macc[p] = '0;
              mcnt[p] = 0;
            end else begin
              macc[p] = macc[p] + pv;
              mcnt[p]++;
            end
          end
        end
      end
    end
    g++;
    rel_c++;
  endtask

  task automatic clear_stats();
    rel_c = 0;
    for (int p = 0; p < N; p++) begin
      pcnt[p] = 0; pfirst_c[p] = -1; pfirst_v[p] = '0; plast_v[p] = '0;
    end
  endtask

  task automatic do_reset();
    step(1'b1);
    step(1'b1);
    clear_stats();
  endtask

  task automatic fill(input int n, input int a, input int b);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < R; i++) begin ba[i][k] = 8'(a); bav[i][k] = 1'b1; end
      for (int j = 0; j < C; j++) begin bb[j][k] = 8'(b); bbv[j][k] = 1'b1; end
    end
  endtask

  // Lane i delivers beat k at relative cycle k+i.
  task automatic run_beats(input int n, input int ncyc);
    int k;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < R; i++) begin
        k = c - i;
        if (k >= 0 && k < n) begin drv_a[i] = ba[i][k]; drv_av[i] = bav[i][k]; end
        else begin drv_a[i] = '0; drv_av[i] = 1'b0; end
      end
      for (int j = 0; j < C; j++) begin
        k = c - j;
        if (k >= 0 && k < n) begin drv_b[j] = bb[j][k]; drv_bv[j] = bbv[j][k]; end
        else begin drv_b[j] = '0; drv_bv[j] = 1'b0; end
      end
      step(1'b0);
    end
  endtask

  initial begin
    int total;
    for (int p = 0; p < N; p++) begin macc[p] = '0; mcnt[p] = 0; exp_d[p] = '0; end
    clear_stats();

    do_reset();
    check("reset_mvalid", mvalid, 64'h0);
    for (int p = 0; p < N; p++)
      check($sformatf("reset_mdata_pe%0d", p), {32'h0, mdata[p*32 +: 32]}, 64'h0);

    // 4-term windows of 1*2 on every PE.
    sc = 16'd3;
    fill(4, 1, 2);
    clear_stats();
    run_beats(4, 22);
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        check($sformatf("t1_cnt_%0d_%0d", i, j), 64'(pcnt[i*C+j]), 64'd1);
        check($sformatf("t1_val_%0d_%0d", i, j), {32'h0, pfirst_v[i*C+j]}, 64'd8);
        check($sformatf("t1_cyc_%0d_%0d", i, j), 64'(pfirst_c[i*C+j]), 64'(4 + i + j));
      end
    end

    // Single-product window with the most negative operands.
    do_reset();
    sc = 16'd0;
    fill(1, 0, 0);
    for (int i = 1; i < R; i++) bav[i][0] = 1'b0;
    for (int j = 1; j < C; j++) bbv[j][0] = 1'b0;
    ba[0][0] = 8'sh80;
    bb[0][0] = 8'sh80;
    run_beats(1, 19);
    check("t2_val", {32'h0, mdata[31:0]}, 64'd16384);
    check("t2_cnt", 64'(pcnt[0]), 64'd1);
    check("t2_cyc", 64'(pfirst_c[0]), 64'd1);
    total = 0;
    for (int p = 0; p < N; p++) total += pcnt[p];
    check("t2_total", 64'(total), 64'd1);

    // Two back-to-back 432-term windows: +1*1 then -1*1.
    do_reset();
    sc = 16'd431;
    fill(864, 1, 1);
    for (int k = 432; k < 864; k++)
      for (int i = 0; i < R; i++) ba[i][k] = -8'sd1;
    run_beats(864, 882);
    for (int p = 0; p < N; p++) begin
      check($sformatf("t3_cnt_pe%0d", p), 64'(pcnt[p]), 64'd2);
      check($sformatf("t3_first_pe%0d", p), {32'h0, pfirst_v[p]}, 64'd432);
      check($sformatf("t3_last_pe%0d", p), {32'h0, plast_v[p]}, 64'hFFFF_FE50);
    end

    // Column-0 weight invalid at beat 1: PE(0,0) fires beats 0,2 then 3,4.
    do_reset();
    sc = 16'd1;
    fill(5, 0, 0);
    for (int k = 0; k < 5; k++) begin
      ba[0][k] = 8'sd3;
      bb[0][k] = 8'(k + 1);
    end
    bbv[0][1] = 1'b0;
    run_beats(5, 23);
    check("t4_cnt", 64'(pcnt[0]), 64'd2);
    check("t4_first", {32'h0, pfirst_v[0]}, 64'd12);
    check("t4_last", {32'h0, plast_v[0]}, 64'd27);
    check("t4_cyc", 64'(pfirst_c[0]), 64'd3);

    // Reset two beats into a window, then a fresh 4-beat window.
    do_reset();
    sc = 16'd3;
    fill(4, 1, 1);
    run_beats(4, 2);
    step(1'b1);
    step(1'b1);
    run_beats(4, 22);
    for (int p = 0; p < N; p++) begin
      check($sformatf("t5_cnt_pe%0d", p), 64'(pcnt[p]), 64'd1);
      check($sformatf("t5_val_pe%0d", p), {32'h0, pfirst_v[p]}, 64'd4);
    end

    // Random operands and valid gaps; the per-cycle model comparison does the checking.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      sc = 16'($urandom_range(15));
      for (int k = 0; k < 48; k++) begin
        for (int i = 0; i < R; i++) begin
          ba[i][k] = 8'($urandom);
          bav[i][k] = ($urandom_range(9) < 8);
        end
        for (int j = 0; j < C; j++) begin
          bb[j][k] = 8'($urandom);
          bbv[j][k] = ($urandom_range(9) < 8);
        end
      end
      run_beats(48, 66);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
